// File: rtl/xgriscv_mmio_timer.sv
// MMIO timer: prescaled counter, compare match, W1C flag, level irq; XGRISCV_TIMER_WDOG_EN adds a watchdog at 0x14.
// Latency: reads are combinational from daddr; writes and counting update on the clk edge.
// Backpressure: none; every store is accepted in its cycle.
module xgriscv_mmio_timer #(
  parameter logic [31:0] BASE_ADDR = 32'h0200_0000,
  parameter int          CNT_W     = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memwrite,
  input  logic [3:0]  amp,
  input  logic [31:0] daddr,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        sel,
  output logic        irq,
  output logic        wdog_rst
);

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++)
      if (be[i]) r[8*i +: 8] = wd[8*i +: 8];
    return r;
  endfunction

  logic             en, ar, ie, flag;
  logic [CNT_W-1:0] count, compare, cnt_inc;
  logic [15:0]      prescale, psc_cnt;
  logic [2:0]       off;
  logic             wr, wr_ctrl, wr_stat, wr_cnt, wr_cmp, wr_psc;
  logic             en_off, tick, match, w1c;
  logic [31:0]      ctrl_new, cnt_new, cmp_new, psc_new, rd;

  assign sel     = (daddr[31:5] == BASE_ADDR[31:5]);
  assign off     = daddr[4:2];
  assign wr      = memwrite & sel;
  assign wr_ctrl = wr & (off == 3'd0);
  assign wr_stat = wr & (off == 3'd1);
  assign wr_cnt  = wr & (off == 3'd2);
  assign wr_cmp  = wr & (off == 3'd3);
  assign wr_psc  = wr & (off == 3'd4);

  assign ctrl_new = merge({29'd0, ie, ar, en}, writedata, amp);
  assign cnt_new  = merge(32'(count), writedata, amp);
  assign cmp_new  = merge(32'(compare), writedata, amp);
  assign psc_new  = merge({16'd0, prescale}, writedata, amp);

  // A CTRL store that clears en suppresses the tick on the same edge.
  assign en_off  = wr_ctrl & ~ctrl_new[0];
  assign tick    = en & (psc_cnt == prescale) & ~en_off;
  assign cnt_inc = count + CNT_W'(1);
  assign match   = tick & ~wr_cnt & (cnt_inc == compare);
  assign w1c     = wr_stat & amp[0] & writedata[0];
  assign irq     = flag & ie;

  always_ff @(posedge clk) begin
    if (reset) begin
      en       <= 1'b0;
      ar       <= 1'b0;
      ie       <= 1'b0;
      flag     <= 1'b0;
      count    <= '0;
      compare  <= '1;
      prescale <= 16'd0;
      psc_cnt  <= 16'd0;
    end else begin
      if (wr_ctrl) {ie, ar, en} <= ctrl_new[2:0];
      if (match)    flag <= 1'b1;
      else if (w1c) flag <= 1'b0;
      if (wr_cnt)    count <= cnt_new[CNT_W-1:0];
      else if (tick) count <= (match & ar) ? '0 : cnt_inc;
      if (wr_cmp) compare  <= cmp_new[CNT_W-1:0];
      if (wr_psc) prescale <= psc_new[15:0];
      if (wr_psc | tick | ~en | en_off) psc_cnt <= 16'd0;
      else                              psc_cnt <= psc_cnt + 16'd1;
    end
  end

`ifdef XGRISCV_TIMER_WDOG_EN
  logic        wen, wr_wd, wd_hit;
  logic [15:0] wd_limit, wd_cnt;
  logic [31:0] wd_new;

  assign wr_wd    = wr & (off == 3'd5);
  assign wd_new   = merge({wen, 15'd0, wd_limit}, writedata, amp);
  assign wd_hit   = wen & flag & (wd_limit != 16'd0) & (wd_cnt == wd_limit);
  assign wdog_rst = wd_hit;

  // Runs only while an expiry is left unserviced; the hit itself restarts the count.
  always_ff @(posedge clk) begin
    if (reset) begin
      wen      <= 1'b0;
      wd_limit <= 16'd0;
      wd_cnt   <= 16'd0;
    end else begin
      if (wr_wd) {wen, wd_limit} <= {wd_new[31], wd_new[15:0]};
      if (~flag | wd_hit) wd_cnt <= 16'd0;
      else if (wen)       wd_cnt <= wd_cnt + 16'd1;
    end
  end

  logic unused_wd;
  assign unused_wd = &{1'b0, wd_new[30:16]};
`else
  assign wdog_rst = 1'b0;
`endif

  always_comb begin
    rd = 32'd0;
    if (sel) begin
      case (off)
        3'd0: rd = {29'd0, ie, ar, en};
        3'd1: rd = {31'd0, flag};
        3'd2: rd = 32'(count);
        3'd3: rd = 32'(compare);
        3'd4: rd = {16'd0, prescale};
`ifdef XGRISCV_TIMER_WDOG_EN
        3'd5: rd = {wen, 15'd0, wd_limit};
`endif
        default: rd = 32'd0;
      endcase
    end
    readdata = rd;
  end

  logic unused_bits;
  assign unused_bits = &{1'b0, daddr[1:0], ctrl_new[31:3], psc_new[31:16]};

endmodule
